// File: rtl/ffi_arbiter.sv
// Round-robin arbiter in front of a shared feedforward-inhibition stage: grants one
// spike volley, counts its spikes against a runtime threshold and forwards it or zeros.
module ffi_arbiter #(
    parameter int unsigned RF      = 16,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 8,
    localparam int unsigned PC_W   = $clog2(RF + 1),
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*RF-1:0] req_spikes,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [PC_W-1:0]       ffi_thresh,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RF-1:0]         out_spikes,
    output logic [ID_W-1:0]       out_id,
    output logic                  out_inhibited,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      inhib_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [RF-1:0]     vol_q, vol_d;
    logic [PC_W-1:0]   thr_q, thr_d;
    logic [ID_W-1:0]   gid_q, gid_d;
    logic              out_valid_q, out_valid_d;
    logic [RF-1:0]     out_spikes_q, out_spikes_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic              out_inhib_q, out_inhib_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  inhib_cnt_q, inhib_cnt_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;
    logic [PC_W-1:0]   pop;
    logic              pass;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Spike count of the captured volley; PC_W holds RF without overflow.
    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < RF; i++) begin
            pop = pop + PC_W'(vol_q[i]);
        end
    end

    assign pass = (pop > thr_q);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        vol_d        = vol_q;
        thr_d        = thr_q;
        gid_d        = gid_q;
        out_valid_d  = out_valid_q;
        out_spikes_d = out_spikes_q;
        out_id_d     = out_id_q;
        out_inhib_d  = out_inhib_q;
        pass_cnt_d   = pass_cnt_q;
        inhib_cnt_d  = inhib_cnt_q;
        req_ready    = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    vol_d   = req_spikes[32'(grant_idx)*RF +: RF];
                    thr_d   = ffi_thresh;
                    gid_d   = grant_idx;
                    ptr_d   = ID_W'((32'(grant_idx) + 1) % NUM_REQ);
                    state_d = EVAL;
                end
            end
            EVAL: begin
                out_spikes_d = pass ? vol_q : '0;
                out_inhib_d  = !pass;
                out_id_d     = gid_q;
                out_valid_d  = 1'b1;
                state_d      = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_inhib_q) begin
                        inhib_cnt_d = (inhib_cnt_q == '1) ? inhib_cnt_q : inhib_cnt_q + CNT_W'(1);
                    end else begin
                        pass_cnt_d = (pass_cnt_q == '1) ? pass_cnt_q : pass_cnt_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            vol_q        <= '0;
            thr_q        <= '0;
            gid_q        <= '0;
            out_valid_q  <= 1'b0;
            out_spikes_q <= '0;
            out_id_q     <= '0;
            out_inhib_q  <= 1'b0;
            pass_cnt_q   <= '0;
            inhib_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            vol_q        <= vol_d;
            thr_q        <= thr_d;
            gid_q        <= gid_d;
            out_valid_q  <= out_valid_d;
            out_spikes_q <= out_spikes_d;
            out_id_q     <= out_id_d;
            out_inhib_q  <= out_inhib_d;
            pass_cnt_q   <= pass_cnt_d;
            inhib_cnt_q  <= inhib_cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_spikes    = out_spikes_q;
    assign out_id        = out_id_q;
    assign out_inhibited = out_inhib_q;
    assign pass_cnt      = pass_cnt_q;
    assign inhib_cnt     = inhib_cnt_q;

endmodule

// File: tb/tb_ffi_arbiter.sv
// Self-checking bench for ffi_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_ffi_arbiter;

    localparam int unsigned RF      = 16;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned PC_W    = 5;
    localparam int unsigned ID_W    = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*RF-1:0] req_spikes;
    logic [NUM_REQ-1:0]    req_ready;
    logic [PC_W-1:0]       ffi_thresh;
    logic                  out_valid;
    logic                  out_ready;
    logic [RF-1:0]         out_spikes;
    logic [ID_W-1:0]       out_id;
    logic                  out_inhibited;
    logic [CNT_W-1:0]      pass_cnt;
    logic [CNT_W-1:0]      inhib_cnt;

    ffi_arbiter #(.RF(RF), .NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_spikes(req_spikes), .req_ready(req_ready),
        .ffi_thresh(ffi_thresh),
        .out_valid(out_valid), .out_ready(out_ready), .out_spikes(out_spikes),
        .out_id(out_id), .out_inhibited(out_inhibited),
        .pass_cnt(pass_cnt), .inhib_cnt(inhib_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_pass = 0;
    int exp_inh  = 0;

    typedef struct {
        int          id;
        logic [15:0] spk;
        logic [4:0]  th;
        logic [15:0] exp_spk;
        logic        exp_inh;
    } vec_t;
    vec_t vecs[8];

    // reference model state for the randomized run
    bit [3:0]    pend;
    logic [15:0] rq_data[4];
    int          m_ptr, m_age, m_id, m_pc, m_ic;
    bit          m_busy, m_inh;
    logic [15:0] m_spk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_pass = 0; exp_inh = 0;
        pend = '0; m_ptr = 0; m_age = 0; m_busy = 0; m_pc = 0; m_ic = 0;
    endtask

    // Single-requester volley; threshold is scrambled after capture.
    task automatic do_txn(input int id, input logic [15:0] spk, input logic [4:0] th,
                          input logic [15:0] e_spk, input logic e_inh);
        @(negedge clk);
        req_spikes = '0;
        req_spikes[id*RF +: RF] = spk;
        req_valid = 4'(1 << id); ffi_thresh = th; out_ready = 1'b0;
        #1 check("txn_req_ready", 32'(req_ready), 32'(1 << id));
        @(negedge clk);
        req_valid = '0; ffi_thresh = ~th;
        #1 check("txn_eval_valid", 32'(out_valid), 0);
        @(negedge clk);
        #1;
        check("txn_out_valid", 32'(out_valid), 1);
        check("txn_out_spikes", 32'(out_spikes), 32'(e_spk));
        check("txn_out_id", 32'(out_id), 32'(id));
        check("txn_out_inhibited", 32'(out_inhibited), 32'(e_inh));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (e_inh) exp_inh++; else exp_pass++;
        #1;
        check("txn_valid_cleared", 32'(out_valid), 0);
        check("txn_pass_cnt", 32'(pass_cnt), 32'(exp_pass));
        check("txn_inhib_cnt", 32'(inhib_cnt), 32'(exp_inh));
    endtask

    // Cycle-level random stimulus; mode 1 floods passing volleys to reach saturation.
    task automatic run_random(input int n, input int mode);
        int g;
        logic [3:0] exp_rr;
        bit exp_ov;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && (mode == 1 || $urandom_range(0, 2) == 0)) begin
                    pend[i] = 1'b1;
                    case ($urandom_range(0, 2))
                        0:       rq_data[i] = 16'($urandom);
                        1:       rq_data[i] = 16'($urandom & $urandom);
                        default: rq_data[i] = 16'($urandom | $urandom);
                    endcase
                    if (mode == 1) rq_data[i] = rq_data[i] | 16'h0001;
                end
                req_valid[i] = pend[i];
                req_spikes[i*RF +: RF] = rq_data[i];
            end
            ffi_thresh = (mode == 1) ? 5'd0 : 5'($urandom_range(0, 17));
            out_ready  = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            if (!m_busy) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (g < 0 && pend[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
                end
            end
            exp_rr = (g >= 0) ? 4'(1 << g) : 4'd0;
            exp_ov = m_busy && (m_age >= 2);
            check("rnd_req_ready", 32'(req_ready), 32'(exp_rr));
            check("rnd_out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) begin
                check("rnd_out_spikes", 32'(out_spikes), 32'(m_spk));
                check("rnd_out_id", 32'(out_id), 32'(m_id));
                check("rnd_out_inhibited", 32'(out_inhibited), 32'(m_inh));
            end
            check("rnd_pass_cnt", 32'(pass_cnt), 32'(m_pc));
            check("rnd_inhib_cnt", 32'(inhib_cnt), 32'(m_ic));
            if (exp_ov && out_ready) begin
                m_busy = 0;
                if (m_inh) m_ic = (m_ic < CNT_MAX) ? m_ic + 1 : CNT_MAX;
                else       m_pc = (m_pc < CNT_MAX) ? m_pc + 1 : CNT_MAX;
            end
            if (g >= 0) begin
                m_busy = 1; m_age = 0; m_id = g;
                m_inh  = !($countones(rq_data[g]) > int'(ffi_thresh));
                m_spk  = m_inh ? 16'h0000 : rq_data[g];
                pend[g] = 1'b0;
                m_ptr  = (g + 1) % NUM_REQ;
            end
            if (m_busy) m_age++;
        end
    endtask

    initial begin
        vecs[0] = '{0, 16'h000F, 5'd3,  16'h000F, 1'b0};
        vecs[1] = '{1, 16'h000F, 5'd4,  16'h0000, 1'b1};
        vecs[2] = '{2, 16'hFFFF, 5'd0,  16'hFFFF, 1'b0};
        vecs[3] = '{3, 16'hFFFF, 5'd16, 16'h0000, 1'b1};
        vecs[4] = '{0, 16'h0000, 5'd0,  16'h0000, 1'b1};
        vecs[5] = '{1, 16'h8001, 5'd1,  16'h8001, 1'b0};
        vecs[6] = '{2, 16'hFFFF, 5'd15, 16'hFFFF, 1'b0};
        vecs[7] = '{3, 16'h00FF, 5'd31, 16'h0000, 1'b1};

        rst = 1'b1; req_valid = '0; req_spikes = '0; ffi_thresh = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_spikes", 32'(out_spikes), 0);
        check("rst_out_id", 32'(out_id), 0);
        check("rst_out_inhibited", 32'(out_inhibited), 0);
        check("rst_pass_cnt", 32'(pass_cnt), 0);
        check("rst_inhib_cnt", 32'(inhib_cnt), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            do_txn(vecs[v].id, vecs[v].spk, vecs[v].th, vecs[v].exp_spk, vecs[v].exp_inh);
        end

        // All requesters busy: pointer wrapped to 0, expect 0,1,2,3,0 every 3 cycles.
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) req_spikes[i*RF +: RF] = 16'(16'h0003 << (4 * i));
        req_valid = 4'hF; ffi_thresh = 5'd1; out_ready = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            check("rr_grant", 32'(req_ready), 32'(1 << (n % 4)));
            @(negedge clk); #1;
            check("rr_eval_ready", 32'(req_ready), 0);
            check("rr_eval_valid", 32'(out_valid), 0);
            @(negedge clk); #1;
            check("rr_out_valid", 32'(out_valid), 1);
            check("rr_out_id", 32'(out_id), 32'(n % 4));
            check("rr_out_ready", 32'(req_ready), 0);
            exp_pass++;
            @(negedge clk); #1;
            if (n == 4) req_valid = '0;
        end
        check("rr_pass_cnt", 32'(pass_cnt), 32'(exp_pass));

        // Backpressure: hold OUT for 5 cycles with another requester waiting.
        @(negedge clk);
        req_spikes[1*RF +: RF] = 16'h000F; req_spikes[0*RF +: RF] = 16'h0000;
        req_valid = 4'b0011; ffi_thresh = 5'd3; out_ready = 1'b0;
        #1 check("stall_grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = 4'b0001;
        #1 check("stall_eval_ready", 32'(req_ready), 0);
        @(negedge clk); #1;
        for (int s = 0; s < 6; s++) begin
            check("stall_valid", 32'(out_valid), 1);
            check("stall_spikes", 32'(out_spikes), 32'h000F);
            check("stall_id", 32'(out_id), 1);
            check("stall_inhibited", 32'(out_inhibited), 0);
            check("stall_ready", 32'(req_ready), 0);
            check("stall_pass_cnt", 32'(pass_cnt), 32'(exp_pass));
            if (s < 5) begin @(negedge clk); #1; end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; exp_pass++;
        #1;
        check("stall_release_cnt", 32'(pass_cnt), 32'(exp_pass));
        check("stall_release_valid", 32'(out_valid), 0);
        check("stall_next_grant", 32'(req_ready), 32'b0001);

        // Reset while req0's volley is in EVAL.
        @(negedge clk);
        rst = 1'b1; req_valid = '0;
        @(negedge clk); #1;
        check("rst_eval_valid", 32'(out_valid), 0);
        check("rst_eval_pass", 32'(pass_cnt), 0);
        check("rst_eval_inhib", 32'(inhib_cnt), 0);
        check("rst_eval_spikes", 32'(out_spikes), 0);
        rst = 1'b0; exp_pass = 0; exp_inh = 0;
        req_spikes = '0; ffi_thresh = 5'd0; req_valid = 4'b1001;
        #1 check("rst_ptr_zero", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0; out_ready = 1'b1;
        @(negedge clk); #1;
        check("post_rst_valid", 32'(out_valid), 1);
        check("post_rst_id", 32'(out_id), 0);
        check("post_rst_empty_inhib", 32'(out_inhibited), 1);
        @(negedge clk);
        out_ready = 1'b0; exp_inh++;
        #1 check("post_rst_inhib_cnt", 32'(inhib_cnt), 32'(exp_inh));
        do_txn(2, 16'h0F0F, 5'd7, 16'h0F0F, 1'b0);

        do_reset();
        run_random(1500, 0);
        run_random(900, 1);
        check("sat_pass_cnt", 32'(pass_cnt), 32'(CNT_MAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
